// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache fill path (ins_cache and icache_line_fill).
//   ADDR_W / WORD_W    : word-address width and backing-bus data width
//   WORDS_PER_LINE     : words per cache line (power of two)
//   LINE_W / OFFSET_W  : line width in bits, word-offset width within a line
//   fill_state_e       : line-fill FSM encoding
package icache_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 16;
  localparam int unsigned LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int unsigned OFFSET_W       = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDone,
    StErr
  } fill_state_e;

endpackage

// File: rtl/icache_line_fill.sv
// Line-fill engine between ins_cache and a 32-bit backing memory.
// Builds one cache line from WORDS_PER_LINE single-word reads, one outstanding read at a time.
// Ports:
//   clk, rst                 : clock (rising edge), asynchronous active-low reset
//   mem_rd_en, mem_addr      : fill request and miss word address from ins_cache
//   mem_rd_rdy, mem_data     : one-cycle line-ready pulse and the assembled line
//   fill_err                 : one-cycle pulse when the fill is aborted by a bus error
//   bus_rd_en, bus_addr      : backing-memory word read request and word address
//   bus_rd_valid, bus_rdata  : backing-memory read response
//   bus_err                  : backing-memory error, qualified by bus_rd_valid
module icache_line_fill
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd_en,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_rdy,
  output logic [LINE_W-1:0] mem_data,
  output logic              fill_err,
  output logic              bus_rd_en,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_rd_valid,
  input  logic [WORD_W-1:0] bus_rdata,
  input  logic              bus_err
);

  fill_state_e                          state_q;
  logic [ADDR_W-OFFSET_W-1:0]           tag_q;    // line-aligned base, offset bits dropped
  logic [OFFSET_W-1:0]                  cnt_q;
  logic [OFFSET_W-1:0]                  cnt_inc;
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_q;
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_wr;
  logic                                 unused_offset;

  // The word offset of the miss address is irrelevant: fills always start at word 0.
  assign unused_offset = ^mem_addr[OFFSET_W-1:0];

  // Offset arithmetic stays inside OFFSET_W bits, so the line address never carries.
  assign cnt_inc = cnt_q + OFFSET_W'(1);

  // Line contents with the current response written into its slot.
  always_comb begin
    line_wr        = line_q;
    line_wr[cnt_q] = bus_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tag_q      <= '0;
      cnt_q      <= '0;
      line_q     <= '0;
      mem_data   <= '0;
      mem_rd_rdy <= 1'b0;
      fill_err   <= 1'b0;
      bus_rd_en  <= 1'b0;
      bus_addr   <= '0;
    end else begin
      // Pulse outputs default low; the state that owns them raises them for one cycle.
      mem_rd_rdy <= 1'b0;
      fill_err   <= 1'b0;
      bus_rd_en  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_rd_en) begin
            tag_q     <= mem_addr[ADDR_W-1:OFFSET_W];
            cnt_q     <= '0;
            bus_addr  <= {mem_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            bus_rd_en <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          if (bus_rd_valid) begin
            if (bus_err) begin
              fill_err <= 1'b1;
              state_q  <= StErr;
            end else begin
              line_q <= line_wr;
              if (cnt_q == OFFSET_W'(WORDS_PER_LINE - 1)) begin
                // Publish the line only on a complete, error-free fill.
                mem_data   <= line_wr;
                mem_rd_rdy <= 1'b1;
                state_q    <= StDone;
              end else begin
                cnt_q     <= cnt_inc;
                bus_addr  <= {tag_q, cnt_inc};
                bus_rd_en <= 1'b1;
                state_q   <= StIssue;
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        StErr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
